// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared declarations for the velocity sweep sequencer: the sequencer state
// enumeration and width helpers used to size channel and counter registers.
// No ports (package).
// -----------------------------------------------------------------------------
package sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_UP    = 3'd2,
      ST_DOWN  = 3'd3,
      ST_FAULT = 3'd4
   } sweep_state_t;

   // Channel index spans both half-sweeps: 0..2*CHANNELS-1.
   function automatic int ch_width(input int channels);
      return (channels > 1) ? $clog2(2 * channels) : 1;
   endfunction

   // Bits needed to hold a counter running 0..count-1 (at least one bit).
   function automatic int cnt_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage : sweep_pkg

// File: rtl/sweep_sequencer_flag_debounce.sv
// -----------------------------------------------------------------------------
// flag_debounce
// Qualifies one direction flag: the flag must be high while the opposing flag
// is low on HOLD_CYCLES consecutive samples. 'qualified' is combinational and
// asserts during the cycle that presents the HOLD_CYCLES-th good sample, so the
// consumer can act on that very edge. The counter then saturates and does not
// re-qualify until a bad sample breaks the run.
//
// Ports:
//   slow_clk  in   clock (rising edge)
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous clear of the hold counter
//   flag      in   flag being qualified
//   other     in   opposing flag (must be low for a good sample)
//   qualified out  high for exactly one sample when the run completes
// -----------------------------------------------------------------------------
module flag_debounce
   import sweep_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic slow_clk,
   input  logic rst,
   input  logic clr,
   input  logic flag,
   input  logic other,
   output logic qualified
);

   // Counter runs 0..HOLD_CYCLES; the top value is the saturated state.
   localparam int HC_W = cnt_width(HOLD_CYCLES + 1);
   localparam logic [HC_W-1:0] HOLD_SAT  = HC_W'(HOLD_CYCLES);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

   logic [HC_W-1:0] hold_cnt_reg;
   logic [HC_W-1:0] hold_cnt_next;
   logic            sample_ok;

   // Both-high and both-low samples both count as breaks.
   assign sample_ok = flag & ~other;

   always_comb begin
      hold_cnt_next = hold_cnt_reg;
      qualified     = 1'b0;
      if (clr || !sample_ok) begin
         hold_cnt_next = '0;
      end else if (hold_cnt_reg != HOLD_SAT) begin
         hold_cnt_next = hold_cnt_reg + HC_W'(1);
         qualified     = (hold_cnt_reg == HOLD_LAST);
      end
   end

   always_ff @(posedge slow_clk or posedge rst) begin
      if (rst) begin
         hold_cnt_reg <= '0;
      end else begin
         hold_cnt_reg <= hold_cnt_next;
      end
   end

endmodule : flag_debounce

// File: rtl/sweep_sequencer.sv
// -----------------------------------------------------------------------------
// sweep_sequencer
// Steps a velocity channel index up through 0..CHANNELS-1 while the drive is
// rising and through CHANNELS..2*CHANNELS-1 while it is falling. Direction
// changes come from debounced rising/falling flags. A watchdog drops into
// FAULT if no qualified direction change occurs for TIMEOUT_CYCLES cycles.
//
// Ports:
//   slow_clk     in   clock (rising edge)
//   rst          in   asynchronous active-high reset
//   enable       in   run request; low returns to IDLE on the next edge
//   rising       in   edge-detector "rising" level flag
//   falling      in   edge-detector "falling" level flag
//   channel      out  current velocity channel
//   ch_valid     out  channel is live (UP or DOWN)
//   dir          out  1 while in UP
//   sweep_start  out  one-cycle pulse after each entry to UP
//   sweep_count  out  completed full sweeps (DOWN->UP transitions), wraps
//   fault        out  watchdog fault (FAULT state)
//   ch_overflow  out  sticky: a channel increment was blocked at the limit
// -----------------------------------------------------------------------------
module sweep_sequencer
   import sweep_pkg::*;
#(
   parameter int CHANNELS       = 512,
   parameter int DWELL_CYCLES   = 100,
   parameter int HOLD_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int CNT_W          = 16
) (
   input  logic                           slow_clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic                           rising,
   input  logic                           falling,
   output logic [ch_width(CHANNELS)-1:0]  channel,
   output logic                           ch_valid,
   output logic                           dir,
   output logic                           sweep_start,
   output logic [CNT_W-1:0]               sweep_count,
   output logic                           fault,
   output logic                           ch_overflow
);

   localparam int CH_W = ch_width(CHANNELS);
   localparam int DW_W = cnt_width(DWELL_CYCLES);
   localparam int TO_W = cnt_width(TIMEOUT_CYCLES);

   localparam logic [CH_W-1:0] CH_UP_FIRST  = '0;
   localparam logic [CH_W-1:0] CH_UP_LAST   = CH_W'(CHANNELS - 1);
   localparam logic [CH_W-1:0] CH_DN_FIRST  = CH_W'(CHANNELS);
   localparam logic [CH_W-1:0] CH_DN_LAST   = CH_W'(2 * CHANNELS - 1);
   localparam logic [DW_W-1:0] DWELL_LAST   = DW_W'(DWELL_CYCLES - 1);
   localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Flag qualification: index 0 = rising, index 1 = falling. Each flag is
   // qualified against the other one.
   // ---------------------------------------------------------------------
   logic [1:0] flag_vec;
   logic [1:0] qual_vec;
   logic       hold_clr;
   logic       rise_q;
   logic       fall_q;

   assign flag_vec = {falling, rising};
   assign hold_clr = ~enable;
   assign rise_q   = qual_vec[0];
   assign fall_q   = qual_vec[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_qual
         flag_debounce #(
            .HOLD_CYCLES (HOLD_CYCLES)
         ) u_flag_debounce (
            .slow_clk  (slow_clk),
            .rst       (rst),
            .clr       (hold_clr),
            .flag      (flag_vec[gi]),
            .other     (flag_vec[1-gi]),
            .qualified (qual_vec[gi])
         );
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   sweep_state_t     state_reg,       state_next;
   logic [CH_W-1:0]  channel_reg,     channel_next;
   logic [DW_W-1:0]  dwell_reg,       dwell_next;
   logic [TO_W-1:0]  timeout_reg,     timeout_next;
   logic [CNT_W-1:0] sweep_count_reg, sweep_count_next;
   logic             ch_overflow_reg, ch_overflow_next;
   logic             sweep_start_reg, sweep_start_next;
   logic [CH_W-1:0]  ch_last;

   always_comb begin
      state_next       = state_reg;
      channel_next     = channel_reg;
      dwell_next       = dwell_reg;
      timeout_next     = timeout_reg;
      sweep_count_next = sweep_count_reg;
      ch_overflow_next = ch_overflow_reg;
      sweep_start_next = 1'b0;
      ch_last          = (state_reg == ST_DOWN) ? CH_DN_LAST : CH_UP_LAST;

      if (!enable) begin
         // Dropping enable outranks every event, including a qualified flag
         // or a timeout on the same edge. Channel keeps its last value.
         state_next       = ST_IDLE;
         dwell_next       = '0;
         timeout_next     = '0;
         sweep_count_next = '0;
         ch_overflow_next = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next = ST_ARM;
            end

            ST_ARM: begin
               // First entry to UP does not count as a completed sweep.
               if (rise_q) begin
                  state_next       = ST_UP;
                  channel_next     = CH_UP_FIRST;
                  dwell_next       = '0;
                  timeout_next     = '0;
                  sweep_start_next = 1'b1;
               end
            end

            ST_UP, ST_DOWN: begin
               // A direction change is checked before the watchdog so that
               // it wins when both land on the same edge.
               if ((state_reg == ST_UP) && fall_q) begin
                  state_next   = ST_DOWN;
                  channel_next = CH_DN_FIRST;
                  dwell_next   = '0;
                  timeout_next = '0;
               end else if ((state_reg == ST_DOWN) && rise_q) begin
                  state_next       = ST_UP;
                  channel_next     = CH_UP_FIRST;
                  dwell_next       = '0;
                  timeout_next     = '0;
                  sweep_start_next = 1'b1;
                  sweep_count_next = sweep_count_reg + CNT_W'(1);
               end else if (timeout_reg == TIMEOUT_LAST) begin
                  state_next = ST_FAULT;
               end else begin
                  timeout_next = timeout_reg + TO_W'(1);
                  if (dwell_reg == DWELL_LAST) begin
                     dwell_next = '0;
                     if (channel_reg == ch_last) begin
                        ch_overflow_next = 1'b1;
                     end else begin
                        channel_next = channel_reg + CH_W'(1);
                     end
                  end else begin
                     dwell_next = dwell_reg + DW_W'(1);
                  end
               end
            end

            ST_FAULT: begin
               // Only dropping enable leaves FAULT.
               state_next = ST_FAULT;
            end

            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge slow_clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         channel_reg     <= '0;
         dwell_reg       <= '0;
         timeout_reg     <= '0;
         sweep_count_reg <= '0;
         ch_overflow_reg <= 1'b0;
         sweep_start_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         channel_reg     <= channel_next;
         dwell_reg       <= dwell_next;
         timeout_reg     <= timeout_next;
         sweep_count_reg <= sweep_count_next;
         ch_overflow_reg <= ch_overflow_next;
         sweep_start_reg <= sweep_start_next;
      end
   end

   // Status outputs decode straight from registers, so an asynchronous reset
   // shows on every output immediately.
   assign channel     = channel_reg;
   assign ch_valid    = (state_reg == ST_UP) || (state_reg == ST_DOWN);
   assign dir         = (state_reg == ST_UP);
   assign fault       = (state_reg == ST_FAULT);
   assign sweep_start = sweep_start_reg;
   assign sweep_count = sweep_count_reg;
   assign ch_overflow = ch_overflow_reg;

endmodule : sweep_sequencer

// File: tb/tb_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sweep_sequencer
// Directed bench for sweep_sequencer with CHANNELS=8, DWELL_CYCLES=4,
// HOLD_CYCLES=3, TIMEOUT_CYCLES=64. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_sweep_sequencer;
   import sweep_pkg::*;

   localparam int CHANNELS = 8;
   localparam int DWELL    = 4;
   localparam int HOLD     = 3;
   localparam int TIMEOUT  = 64;
   localparam int CNT_W    = 16;
   localparam int CH_W     = ch_width(CHANNELS);

   logic             slow_clk = 1'b0;
   logic             rst;
   logic             enable;
   logic             rising;
   logic             falling;
   logic [CH_W-1:0]  channel;
   logic             ch_valid;
   logic             dir;
   logic             sweep_start;
   logic [CNT_W-1:0] sweep_count;
   logic             fault;
   logic             ch_overflow;

   int checks   = 0;
   int failures = 0;

   sweep_sequencer #(
      .CHANNELS       (CHANNELS),
      .DWELL_CYCLES   (DWELL),
      .HOLD_CYCLES    (HOLD),
      .TIMEOUT_CYCLES (TIMEOUT),
      .CNT_W          (CNT_W)
   ) dut (
      .slow_clk    (slow_clk),
      .rst         (rst),
      .enable      (enable),
      .rising      (rising),
      .falling     (falling),
      .channel     (channel),
      .ch_valid    (ch_valid),
      .dir         (dir),
      .sweep_start (sweep_start),
      .sweep_count (sweep_count),
      .fault       (fault),
      .ch_overflow (ch_overflow)
   );

   always #5 slow_clk = ~slow_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge slow_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst     = 1'b1;
      enable  = 1'b0;
      rising  = 1'b0;
      falling = 1'b0;
      ticks(2);

      // Reset state
      chk("rst_channel",  32'(channel),     0);
      chk("rst_ch_valid", 32'(ch_valid),    0);
      chk("rst_dir",      32'(dir),         0);
      chk("rst_start",    32'(sweep_start), 0);
      chk("rst_count",    32'(sweep_count), 0);
      chk("rst_fault",    32'(fault),       0);
      chk("rst_overflow", 32'(ch_overflow), 0);
      rst = 1'b0;

      // Arm and qualify rise: UP lands on the 3rd edge
      enable = 1'b1;
      rising = 1'b1;
      tick();
      chk("arm_e1_valid", 32'(ch_valid), 0);
      tick();
      chk("arm_e2_dir",   32'(dir), 0);
      tick();
      $display("step: enter UP dir=%0d start=%0d ch=%0d", dir, sweep_start, channel);
      chk("up_entry_dir",   32'(dir),         1);
      chk("up_entry_valid", 32'(ch_valid),    1);
      chk("up_entry_start", 32'(sweep_start), 1);
      chk("up_entry_ch",    32'(channel),     0);
      chk("up_entry_count", 32'(sweep_count), 0);
      rising = 1'b0;
      tick();                                    // k=1
      chk("up_start_pulse_end", 32'(sweep_start), 0);
      ticks(2);                                  // k=3
      chk("up_k3_ch", 32'(channel), 0);
      tick();                                    // k=4
      chk("up_k4_ch", 32'(channel), 1);
      ticks(4);                                  // k=8
      chk("up_k8_ch", 32'(channel), 2);
      chk("up_k8_ovf", 32'(ch_overflow), 0);

      // Saturation at 7; blocked increment at k=32 sets overflow
      ticks(23);                                 // k=31
      chk("up_k31_ch",  32'(channel), 7);
      chk("up_k31_ovf", 32'(ch_overflow), 0);
      tick();                                    // k=32
      chk("up_k32_ovf", 32'(ch_overflow), 1);
      ticks(8);                                  // k=40
      $display("step: UP k=40 ch=%0d ovf=%0d", channel, ch_overflow);
      chk("up_k40_ch",  32'(channel), 7);
      chk("up_k40_ovf", 32'(ch_overflow), 1);

      // Fall qualifies on 3rd sample -> DOWN, channel 8
      falling = 1'b1;
      ticks(2);
      chk("fall_2_dir", 32'(dir), 1);
      tick();                                    // DOWN d=0
      $display("step: enter DOWN dir=%0d ch=%0d", dir, channel);
      chk("down_dir",   32'(dir),         0);
      chk("down_valid", 32'(ch_valid),    1);
      chk("down_ch",    32'(channel),     8);
      chk("down_ovf",   32'(ch_overflow), 1);
      chk("down_count", 32'(sweep_count), 0);

      // Alternating 2-sample runs: r r f f r r -> no transition
      for (int i = 0; i < 6; i++) begin
         rising  = ((i / 2) % 2 == 0);
         falling = ~rising;
         tick();
         chk("alt_no_start", 32'(sweep_start), 0);
      end                                        // d=6
      chk("alt_dir", 32'(dir),     0);
      chk("alt_ch",  32'(channel), 9);

      // Break the run, then a full rise -> DOWN->UP counts one sweep
      rising  = 1'b0;
      falling = 1'b0;
      tick();                                    // d=7
      rising = 1'b1;
      ticks(2);                                  // d=9
      chk("rise_2_dir", 32'(dir), 0);
      tick();                                    // UP k=0
      $display("step: DOWN->UP count=%0d start=%0d", sweep_count, sweep_start);
      chk("sweep_dir",   32'(dir),         1);
      chk("sweep_start", 32'(sweep_start), 1);
      chk("sweep_count", 32'(sweep_count), 1);
      chk("sweep_ch",    32'(channel),     0);

      // Both flags high for 10 cycles: nothing changes
      falling = 1'b1;
      ticks(10);                                 // k=10
      chk("both_dir",   32'(dir),         1);
      chk("both_ch",    32'(channel),     2);
      chk("both_count", 32'(sweep_count), 1);

      // Back into DOWN, then let the watchdog expire
      rising = 1'b0;
      ticks(3);                                  // DOWN d=0
      chk("down2_dir", 32'(dir),     0);
      chk("down2_ch",  32'(channel), 8);
      falling = 1'b0;
      ticks(63);                                 // d=63
      chk("to_d63_fault", 32'(fault),    0);
      chk("to_d63_valid", 32'(ch_valid), 1);
      chk("to_d63_ch",    32'(channel),  15);
      tick();                                    // d=64
      $display("step: timeout fault=%0d valid=%0d ch=%0d", fault, ch_valid, channel);
      chk("to_fault", 32'(fault),    1);
      chk("to_valid", 32'(ch_valid), 0);
      chk("to_dir",   32'(dir),      0);
      chk("to_ch",    32'(channel),  15);
      ticks(3);
      chk("fault_hold",    32'(fault),   1);
      chk("fault_hold_ch", 32'(channel), 15);

      // Enable low -> IDLE clears fault, overflow, count; channel held
      enable = 1'b0;
      tick();
      $display("step: disable fault=%0d ovf=%0d count=%0d", fault, ch_overflow, sweep_count);
      chk("idle_fault", 32'(fault),       0);
      chk("idle_ovf",   32'(ch_overflow), 0);
      chk("idle_count", 32'(sweep_count), 0);
      chk("idle_valid", 32'(ch_valid),    0);
      chk("idle_ch",    32'(channel),     15);

      // Re-run to mid-UP, then reset between edges
      enable = 1'b1;
      rising = 1'b1;
      ticks(3);
      chk("rerun_start", 32'(sweep_start), 1);
      chk("rerun_count", 32'(sweep_count), 0);
      ticks(5);                                  // k=5
      chk("rerun_ch", 32'(channel), 1);
      #3 rst = 1'b1;
      #1;
      $display("step: async reset ch=%0d dir=%0d valid=%0d", channel, dir, ch_valid);
      chk("arst_ch",    32'(channel),     0);
      chk("arst_dir",   32'(dir),         0);
      chk("arst_valid", 32'(ch_valid),    0);
      chk("arst_start", 32'(sweep_start), 0);
      chk("arst_count", 32'(sweep_count), 0);
      chk("arst_fault", 32'(fault),       0);
      chk("arst_ovf",   32'(ch_overflow), 0);
      #2 rst = 1'b0;

      // After release a fresh qualified rise is needed
      tick();
      chk("post_rst_e1_dir", 32'(dir), 0);
      tick();
      chk("post_rst_e2_dir", 32'(dir), 0);
      tick();
      chk("post_rst_e3_dir",   32'(dir),         1);
      chk("post_rst_e3_start", 32'(sweep_start), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sweep_sequencer

// File: doc/sweep_sequencer.md
SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 512: channels per half-sweep; channel index width CH_W = clog2(2*CHANNELS).
REQ-002 SHALL have parameter DWELL_CYCLES, default 100: clock cycles per channel step.
REQ-003 SHALL have parameter HOLD_CYCLES, default 4: consecutive samples needed to qualify a direction flag.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1048576: maximum cycles without a qualified direction change.
REQ-005 SHALL have parameter CNT_W, default 16: sweep counter width.
REQ-006 SHALL have port slow_clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port enable, input, 1: run request; low forces IDLE.
REQ-009 SHALL have ports rising and falling, input, 1 each: edge-detector level flags, already synchronous to slow_clk.
REQ-010 SHALL have port channel, output, CH_W: current velocity channel.
REQ-011 SHALL have port ch_valid, output, 1: high in UP and DOWN only.
REQ-012 SHALL have port dir, output, 1: 1 = UP, 0 otherwise.
REQ-013 SHALL have port sweep_start, output, 1: one-cycle pulse at each entry to UP.
REQ-014 SHALL have port sweep_count, output, CNT_W: number of completed full sweeps.
REQ-015 SHALL have ports fault and ch_overflow, output, 1 each: timeout fault; sticky channel saturation.

Function
REQ-016 SHALL implement states IDLE, ARM, UP, DOWN, FAULT.
REQ-017 SHALL qualify rise when rising=1 and falling=0 on HOLD_CYCLES consecutive samples; fall likewise with the roles swapped; both-high or both-low samples clear both hold counters.
REQ-018 SHALL take the state transition on the same edge that samples the HOLD_CYCLES-th qualifying sample; after qualifying, a hold counter saturates and does not re-qualify until broken.
REQ-019 SHALL transition: IDLE->ARM when enable=1; ARM->UP on rise; UP->DOWN on fall; DOWN->UP on rise; UP/DOWN->FAULT on timeout; any state->IDLE on the next edge when enable=0 (enable low has priority over all events).
REQ-020 SHALL ignore fall in ARM and UP-qualified rise while already in UP (and fall in DOWN); these do not restart timers.
REQ-021 SHALL on entry to UP set channel=0, clear dwell and timeout counters, and pulse sweep_start.
REQ-022 SHALL on entry to DOWN set channel=CHANNELS and clear dwell and timeout counters.
REQ-023 SHALL in UP/DOWN count dwell 0..DWELL_CYCLES-1, incrementing channel on the wrap edge.
REQ-024 SHALL saturate channel at CHANNELS-1 in UP and 2*CHANNELS-1 in DOWN, setting ch_overflow on any blocked increment.
REQ-025 SHALL increment sweep_count, modulo 2^CNT_W, on each DOWN->UP transition (not ARM->UP).
REQ-026 SHALL enter FAULT when the timeout counter reaches TIMEOUT_CYCLES-1 in UP/DOWN; FAULT drives fault=1, ch_valid=0, and holds channel.
REQ-027 SHALL clear ch_overflow, fault and sweep_count on entry to IDLE; channel holds its last value outside UP/DOWN.
REQ-028 SHALL give a timeout and a qualified direction change on the same edge: the direction change wins.

Reset
REQ-029 SHALL on rst=1 immediately force state=IDLE, channel=0, ch_valid=0, dir=0, sweep_start=0, sweep_count=0, fault=0, ch_overflow=0, and all internal counters 0.
REQ-030 SHALL on rst mid-sweep abandon the sweep with no sweep_start pulse; after release, operation requires enable and a fresh qualified rise.

Structure
REQ-031 SHALL place the state enumeration and the CH_W derivation in shared package sweep_pkg.
REQ-032 SHALL implement the flag qualifier as one sub-module, flag_debounce, instanced once per flag.

Verification (CHANNELS=8, DWELL_CYCLES=4, HOLD_CYCLES=3, TIMEOUT_CYCLES=64)
REQ-033 SHALL test: enable=1, rising=1 for 3 cycles -> UP on the 3rd edge, sweep_start one cycle, channel 0,1,2 every 4 cycles.
REQ-034 SHALL test: UP held 40 cycles -> channel saturates at 7, ch_overflow=1; then falling for 3 cycles -> DOWN, channel=8.
REQ-035 SHALL test: rising then falling then rising for 2 cycles only, alternating -> no transition and no sweep_start.
REQ-036 SHALL test: full UP->DOWN->UP -> sweep_count 0->1; rising and falling both high for 10 cycles -> no change.
REQ-037 SHALL test: no flag change for 64 cycles in DOWN -> fault=1, ch_valid=0; enable=0 -> IDLE, fault=0.
REQ-038 SHALL test: rst asserted mid-UP between clock edges -> all outputs reset immediately, asynchronously.
